// File: rtl/fdivsqrt_iter_ctrl_pkg.sv
// Shared FPU divide/sqrt definitions: iteration-controller states and default counter width.
package fdivsqrt_iter_ctrl_pkg;

  localparam int unsigned DurLenDefault = 6;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } divstate_e;

endpackage

// File: rtl/fdivsqrt_stepcnt.sv
// Loadable down-counter holding the remaining divide/sqrt iterations.
module fdivsqrt_stepcnt #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] value,
  input  logic             en,
  input  logic             clear,
  output logic [Width-1:0] cnt,
  output logic             one
);

  logic [Width-1:0] cnt_q;

  // Clear beats load so a flush always leaves the counter at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign cnt = cnt_q;
  assign one = (cnt_q == Width'(1));

endmodule

// File: rtl/fdivsqrt_iter_ctrl.sv
// Divide/sqrt iteration controller: IDLE -> BUSY (N steps) -> DONE, with flush and stall.
// Define FDIVSQRT_EARLYTERM_EN to send special-case operands straight to DONE.
module fdivsqrt_iter_ctrl
  import fdivsqrt_iter_ctrl_pkg::*;
#(
  parameter int unsigned DURLEN = DurLenDefault,
  parameter int unsigned MAXCYC = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              FDivStartE,
  input  logic [DURLEN-1:0] CyclesE,
  input  logic              SpecialCaseE,
  input  logic              StallM,
  input  logic              FlushE,
  output logic              FDivBusyE,
  output logic              IFDivStartE,
  output logic              FDivDoneE,
  output logic [DURLEN-1:0] StepCnt
);

  divstate_e         state_q;
  logic              early_term;
  logic              start_seen;
  logic              accept;
  logic              cnt_one;
  logic [DURLEN-1:0] load_val;

`ifdef FDIVSQRT_EARLYTERM_EN
  assign early_term = SpecialCaseE;
`else
  logic unused_special;
  assign unused_special = SpecialCaseE;
  assign early_term     = 1'b0;
`endif

  // Reset gates the combinational start path so outputs drop the instant reset rises.
  assign start_seen = !reset && (state_q == StIdle) && FDivStartE && !FlushE;
  assign accept     = start_seen && !early_term;
  assign load_val   = (CyclesE == '0) ? DURLEN'(1) : CyclesE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else if (FlushE) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (start_seen) state_q <= early_term ? StDone : StBusy;
        StBusy: if (cnt_one) state_q <= StDone;
        StDone: if (!StallM) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  fdivsqrt_stepcnt #(
    .Width(DURLEN)
  ) u_stepcnt (
    .clk  (clk),
    .reset(reset),
    .load (accept),
    .value(load_val),
    .en   (state_q == StBusy),
    .clear(FlushE),
    .cnt  (StepCnt),
    .one  (cnt_one)
  );

  assign IFDivStartE = accept;
  assign FDivBusyE   = (state_q == StBusy) || accept;
  assign FDivDoneE   = (state_q == StDone);

  // Debug bound on the iteration count handed over by the cycle-count stage.
  a_cycles_bound: assert property (@(posedge clk) disable iff (reset)
    accept |-> (32'(CyclesE) <= MAXCYC));

endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// Self-checking bench for fdivsqrt_iter_ctrl against a per-operation timeline model.
module tb_fdivsqrt_iter_ctrl;

  localparam int unsigned DurLen = 6;
`ifdef FDIVSQRT_EARLYTERM_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              FDivStartE;
  logic [DurLen-1:0] CyclesE;
  logic              SpecialCaseE;
  logic              StallM;
  logic              FlushE;
  logic              FDivBusyE;
  logic              IFDivStartE;
  logic              FDivDoneE;
  logic [DurLen-1:0] StepCnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Current operation: requested count, special flag, stall cycles after done, flush cycle.
  int op_n, op_stall, op_flush, op_dstart, op_last;
  bit op_special;

  always #5 clk = ~clk;

  fdivsqrt_iter_ctrl #(
    .DURLEN(DurLen),
    .MAXCYC(40)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .FDivStartE  (FDivStartE),
    .CyclesE     (CyclesE),
    .SpecialCaseE(SpecialCaseE),
    .StallM      (StallM),
    .FlushE      (FlushE),
    .FDivBusyE   (FDivBusyE),
    .IFDivStartE (IFDivStartE),
    .FDivDoneE   (FDivDoneE),
    .StepCnt     (StepCnt)
  );

  task automatic setup_op(int n, bit special, int stall, int flush_at);
    int nn;
    nn         = (n == 0) ? 1 : n;
    op_n       = n;
    op_special = special;
    op_stall   = stall;
    op_flush   = flush_at;
    op_dstart  = (special && Early) ? 1 : nn + 1;
    op_last    = (flush_at >= 0) ? flush_at + 1 : op_dstart + stall + 1;
  endtask

  // Expected {busy, istart, done, stepcnt} in cycle c of an operation started in cycle 0.
  function automatic logic [DurLen+2:0] model_out(int c);
    int                nn    = (op_n == 0) ? 1 : op_n;
    bit                early = op_special && Early;
    logic              b     = 1'b0;
    logic              s     = 1'b0;
    logic              d     = 1'b0;
    logic [DurLen-1:0] cnt   = '0;
    if (op_flush >= 0 && c > op_flush) return '0;
    if (c == 0) begin
      b = !early && (op_flush != 0);
      s = b;
    end else if (c < op_dstart) begin
      b   = 1'b1;
      cnt = DurLen'(nn - (c - 1));
    end else if (c <= op_dstart + op_stall) begin
      d = 1'b1;
    end
    return {b, s, d, cnt};
  endfunction

  // Drive cycle c of the current operation (junk starts/counts while busy), sample mid-cycle.
  task automatic op_cycle(int c, output logic [DurLen+2:0] obs);
    FDivStartE   = (c == 0) ? 1'b1 : ((c < op_last) ? 1'($urandom_range(1, 0)) : 1'b0);
    CyclesE      = (c == 0) ? DurLen'(op_n) : DurLen'($urandom_range(40, 0));
    SpecialCaseE = (c == 0) ? op_special : 1'($urandom_range(1, 0));
    if (c >= op_dstart) StallM = (c < op_dstart + op_stall);
    else                StallM = 1'($urandom_range(1, 0));
    FlushE = (c == op_flush);
    @(negedge clk);
    obs = {FDivBusyE, IFDivStartE, FDivDoneE, StepCnt};
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    FDivStartE   = 1'b0;
    CyclesE      = '0;
    SpecialCaseE = 1'b0;
    StallM       = 1'b0;
    FlushE       = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    n_checks++;
    if ({FDivBusyE, IFDivStartE, FDivDoneE, StepCnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want 0", {FDivBusyE, IFDivStartE, FDivDoneE, StepCnt});
    end
    FDivStartE = 1'b1;
    CyclesE    = 6'd4;
    #1;
    n_checks++;
    if ({FDivBusyE, IFDivStartE, FDivDoneE} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_start: got %b want 000", {FDivBusyE, IFDivStartE, FDivDoneE});
    end
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({FDivBusyE, IFDivStartE, FDivDoneE, StepCnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 0", {FDivBusyE, IFDivStartE, FDivDoneE, StepCnt});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [DurLen+2:0] obs, exp;
    setup_op(5, 1'b0, 0, -1);
    for (int c = 0; c <= op_last; c++) begin
      op_cycle(c, obs);
      exp = model_out(c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL basic c%0d: got %b want %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [DurLen+2:0] obs, exp;
    setup_op(1, 1'b0, 3, -1);
    for (int c = 0; c <= op_last; c++) begin
      op_cycle(c, obs);
      exp = model_out(c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL stall c%0d: got %b want %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_flush();
    logic [DurLen+2:0] obs, exp;
    setup_op(10, 1'b0, 0, 4);
    for (int c = 0; c <= op_last; c++) begin
      op_cycle(c, obs);
      exp = model_out(c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL flush c%0d: got %b want %b", c, obs, exp);
      end
    end
    setup_op(2, 1'b0, 0, -1);
    for (int c = 0; c <= op_last; c++) begin
      op_cycle(c, obs);
      exp = model_out(c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL flush_restart c%0d: got %b want %b", c, obs, exp);
      end
    end
    setup_op(3, 1'b0, 0, 0);
    for (int c = 0; c <= op_last; c++) begin
      op_cycle(c, obs);
      exp = model_out(c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL flush_on_start c%0d: got %b want %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [DurLen+2:0] obs, exp;
    setup_op(6, 1'b0, 0, -1);
    for (int c = 0; c < 4; c++) begin
      op_cycle(c, obs);
      exp = model_out(c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL async_pre c%0d: got %b want %b", c, obs, exp);
      end
    end
    FDivStartE = 1'b1;
    CyclesE    = 6'd9;
    StallM     = 1'b0;
    FlushE     = 1'b0;
    #1;
    n_checks++;
    if ({FDivBusyE, IFDivStartE, FDivDoneE, StepCnt} !== {3'b100, 6'd3}) begin
      n_fail++;
      $display("FAIL async_busy: got %b want %b", {FDivBusyE, IFDivStartE, FDivDoneE, StepCnt},
               {3'b100, 6'd3});
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({FDivBusyE, IFDivStartE, FDivDoneE, StepCnt} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 0", {FDivBusyE, IFDivStartE, FDivDoneE, StepCnt});
    end
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1'b0;
    setup_op(4, 1'b0, 1, -1);
    for (int c = 0; c <= op_last; c++) begin
      op_cycle(c, obs);
      exp = model_out(c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL async_post c%0d: got %b want %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_special();
    logic [DurLen+2:0] obs, exp;
    setup_op(7, 1'b1, 1, -1);
    for (int c = 0; c <= op_last; c++) begin
      op_cycle(c, obs);
      exp = model_out(c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL special c%0d: got %b want %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_zero_cycles();
    logic [DurLen+2:0] obs, exp;
    logic [DurLen+2:0] run0[$];
    logic [DurLen+2:0] run1[$];
    setup_op(0, 1'b0, 0, -1);
    for (int c = 0; c <= op_last; c++) begin
      op_cycle(c, obs);
      run0.push_back(obs);
      exp = model_out(c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL zero c%0d: got %b want %b", c, obs, exp);
      end
    end
    setup_op(1, 1'b0, 0, -1);
    for (int c = 0; c <= op_last; c++) begin
      op_cycle(c, obs);
      run1.push_back(obs);
    end
    n_checks++;
    if (run0 != run1) begin
      n_fail++;
      $display("FAIL zero_vs_one: got %p want %p", run0, run1);
    end
  endtask

  task automatic test_back_to_back();
    logic [DurLen+2:0] obs, exp;
    int ns[3]     = '{2, 3, 1};
    bit sps[3]    = '{1'b0, 1'b1, 1'b0};
    int stalls[3] = '{0, 0, 2};
    for (int k = 0; k < 3; k++) begin
      setup_op(ns[k], sps[k], stalls[k], -1);
      for (int c = 0; c <= op_last; c++) begin
        op_cycle(c, obs);
        exp = model_out(c);
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL b2b op%0d c%0d: got %b want %b", k, c, obs, exp);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [DurLen+2:0] obs, exp;
    for (int k = 0; k < 25; k++) begin
      setup_op($urandom_range(12, 0), 1'($urandom_range(1, 0)), $urandom_range(3, 0), -1);
      if ($urandom_range(2, 0) == 0) begin
        op_flush = $urandom_range(op_dstart + op_stall, 0);
        op_last  = op_flush + 1;
      end
      for (int c = 0; c <= op_last; c++) begin
        op_cycle(c, obs);
        exp = model_out(c);
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL random op%0d n%0d sp%0d st%0d fl%0d c%0d: got %b want %b", k, op_n,
                   op_special, op_stall, op_flush, c, obs, exp);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_async_reset();
    test_special();
    test_zero_cycles();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
